// File: rtl/fp_operand_loader.sv
// Byte-serial loader for the A/B operand pair of the FP multiply core.
// Synchronizes an async strobe, assembles two 32-bit words, hands off via valid/ready.
module fp_operand_loader #(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  byte_in,
  input  logic        byte_strobe,
  input  logic        clear,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [2:0]  byte_count,
  output logic        overrun
);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [31:0]            a_q, a_d;
  logic [31:0]            b_q, b_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   ovr_q, ovr_d;
  logic                   cap;

  function automatic logic [31:0] shift_in(
    input logic [31:0] x,
    input logic [7:0]  b
  );
    if (MSB_FIRST) return {x[23:0], b};
    else           return {b, x[31:8]};
  endfunction

  assign cap = sync_q[SYNC_STAGES-1] & ~edge_q & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      state_q <= LOAD;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], byte_strobe};
      edge_q  <= sync_q[SYNC_STAGES-1];
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (clear) begin
      // a transfer in the same cycle is subsumed: result is plain LOAD
      state_d = LOAD;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (cap) begin
            if (cnt_q[2]) b_d = shift_in(b_q, byte_in);
            else          a_d = shift_in(a_q, byte_in);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = HOLD;
          end
        end
        HOLD: begin
          if (cap) ovr_d = 1'b1;
          if (op_ready) state_d = LOAD;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  assign op_valid   = (state_q == HOLD);
  assign op_a       = a_q;
  assign op_b       = b_q;
  assign byte_count = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Bench for fp_operand_loader: MSB-first and LSB-first instances share stimulus
// and are checked against a byte-queue model of the frame.
module tb_fp_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n, ena, byte_strobe, clear, op_ready;
  logic [7:0]  byte_in;
  logic        v_m, v_l, o_m, o_l;
  logic [31:0] a_m, b_m, a_l, b_l;
  logic [2:0]  c_m, c_l;

  int total = 0;
  int bad   = 0;
  int vcnt_m = 0;
  int vcnt_l = 0;

  logic [7:0]  fb[$];
  bit          hold, ovr;
  logic [31:0] ea_m, eb_m, ea_l, eb_l;

  always #5 clk = ~clk;

  fp_operand_loader #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .ena(ena), .byte_in(byte_in),
    .byte_strobe(byte_strobe), .clear(clear), .op_valid(v_m),
    .op_ready(op_ready), .op_a(a_m), .op_b(b_m),
    .byte_count(c_m), .overrun(o_m)
  );

  fp_operand_loader #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .ena(ena), .byte_in(byte_in),
    .byte_strobe(byte_strobe), .clear(clear), .op_valid(v_l),
    .op_ready(op_ready), .op_a(a_l), .op_b(b_l),
    .byte_count(c_l), .overrun(o_l)
  );

  always @(negedge clk) begin
    if (v_m === 1'b1) vcnt_m++;
    if (v_l === 1'b1) vcnt_l++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    fb.delete();
    hold = 1'b0;
    ovr  = 1'b0;
    ea_m = '0; eb_m = '0; ea_l = '0; eb_l = '0;
  endfunction

  function automatic void model_cap(input logic [7:0] b);
    if (!ena) return;
    if (hold) begin
      ovr = 1'b1;
      return;
    end
    fb.push_back(b);
    if (fb.size() == 8) begin
      ea_m = {fb[0], fb[1], fb[2], fb[3]};
      eb_m = {fb[4], fb[5], fb[6], fb[7]};
      ea_l = {fb[3], fb[2], fb[1], fb[0]};
      eb_l = {fb[7], fb[6], fb[5], fb[4]};
      fb.delete();
      hold = 1'b1;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":valid_m"}, 32'(v_m), 32'(hold));
    chk({tag, ":valid_l"}, 32'(v_l), 32'(hold));
    chk({tag, ":cnt_m"}, 32'(c_m), 32'(fb.size()));
    chk({tag, ":cnt_l"}, 32'(c_l), 32'(fb.size()));
    chk({tag, ":ovr_m"}, 32'(o_m), 32'(ovr));
    chk({tag, ":ovr_l"}, 32'(o_l), 32'(ovr));
    if (fb.size() == 0) begin
      chk({tag, ":a_m"}, a_m, ea_m);
      chk({tag, ":b_m"}, b_m, eb_m);
      chk({tag, ":a_l"}, a_l, ea_l);
      chk({tag, ":b_l"}, b_l, eb_l);
    end
  endtask

  task automatic strobe(input logic [7:0] b, input int hi);
    @(negedge clk);
    byte_in     = b;
    byte_strobe = 1'b1;
    model_cap(b);
    repeat (hi) @(negedge clk);
    byte_strobe = 1'b0;
    repeat (3) @(negedge clk);
    if (hold && op_ready) hold = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  logic [7:0] t2[8] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
  logic [7:0] t5[8] = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00};
  logic [7:0] t6[8] = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40};

  initial begin
    int v0m, v0l;
    logic [7:0] rb;
    rst_n = 1'b0; ena = 1'b1; byte_strobe = 1'b0; clear = 1'b0;
    op_ready = 1'b0; byte_in = 8'h00;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("init");

    // reset mid-cycle with partial data loaded
    for (int i = 0; i < 3; i++) strobe(8'($urandom_range(1, 255)), 3);
    check_all("partial");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_clear();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("rst_rel");

    // nominal frame, consumer always ready
    op_ready = 1'b1;
    v0m = vcnt_m; v0l = vcnt_l;
    for (int i = 0; i < 8; i++) strobe(t2[i], 3);
    check_all("nominal");
    chk("pulse_m", 32'(vcnt_m - v0m), 32'd1);
    chk("pulse_l", 32'(vcnt_l - v0l), 32'd1);
    op_ready = 1'b0;

    // strobe latency: written at E+2
    @(negedge clk);
    rb = 8'($urandom);
    byte_in = rb;
    byte_strobe = 1'b1;
    @(negedge clk);
    chk("lat_E", 32'(c_m), 32'd0);
    @(negedge clk);
    chk("lat_E1", 32'(c_m), 32'd0);
    @(negedge clk);
    chk("lat_E2", 32'(c_m), 32'd1);
    model_cap(rb);
    byte_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check_all("lat_done");
    strobe(8'($urandom), 1);
    check_all("glitch");

    // complete frame, then backpressure
    for (int i = 0; i < 6; i++) strobe(8'($urandom), 3);
    check_all("full_bp");
    strobe(8'($urandom), 3);
    strobe(8'($urandom), 3);
    check_all("overrun");
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    hold = 1'b0;
    check_all("accept");
    repeat (4) @(negedge clk);
    check_all("ovr_sticky");

    // clear mid-frame
    for (int i = 0; i < 3; i++) strobe(8'($urandom_range(1, 255)), 3);
    check_all("pre_clear");
    do_clear();
    check_all("clear");
    for (int i = 0; i < 8; i++) strobe(t5[i], 3);
    check_all("after_clear");
    chk("t5_a", a_m, 32'h3F800000);
    chk("t5_b", b_m, 32'hC0000000);

    // clear coinciding with transfer
    @(negedge clk);
    clear = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    op_ready = 1'b0;
    model_clear();
    check_all("clr_xfer");

    // LSB-first vector with an ena pause mid-frame
    for (int i = 0; i < 4; i++) strobe(t6[i], 3);
    ena = 1'b0;
    strobe(8'hEE, 3);
    strobe(8'hDD, 3);
    check_all("ena_pause");
    ena = 1'b1;
    for (int i = 4; i < 8; i++) strobe(t6[i], 3);
    check_all("lsb_frame");
    chk("t6_a", a_l, 32'h3F800000);
    chk("t6_b", b_l, 32'h40000000);
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    hold = 1'b0;

    // strobe held high through reset release
    @(negedge clk);
    rst_n = 1'b0;
    rb = 8'($urandom);
    byte_in = rb;
    byte_strobe = 1'b1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    model_cap(rb);
    repeat (6) @(negedge clk);
    check_all("strobe_thru_rst");
    byte_strobe = 1'b0;
    repeat (3) @(negedge clk);
    do_clear();

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8 + int'($urandom_range(0, 2)); i++) begin
        ena = ($urandom_range(0, 3) != 0);
        strobe(8'($urandom), 3);
        ena = 1'b1;
        check_all($sformatf("rnd%0d_%0d", f, i));
      end
      @(negedge clk);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      if (hold) hold = 1'b0;
      check_all($sformatf("rnd%0d_acc", f));
      if ($urandom_range(0, 1) == 1) do_clear();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
